servo_motion_sequencer: RTL and testbench

Sequences position commands for one servo channel driven by the team's PWM serializer (100 MHz clock, 20 ms frame, duty code 0..99 mapping to a 1.0..~2.0 ms pulse).
- Accepts target/dwell commands over a valid/ready handshake.
- Slews `duty_cycle` toward each target by at most STEP codes per frame, then dwells for the commanded number of frames.
- Changes `duty_cycle` only at frame boundaries, so the serializer never sees a mid-pulse change.
- Sits between the jaw/motion control logic and the serializer's `duty_cycle` input.

---
 rtl/servo_pkg.sv | 65 ++++++
 rtl/servo_frame_timer.sv | 53 +++++
 rtl/servo_motion_sequencer.sv | 159 +++++++++++++++
 tb/tb_servo_motion_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg
//   Shared definitions for the servo motion sequencer and the PWM serializer:
//   sequencer state encoding, duty-code width, default limits and the frame
//   length. Also carries the pure arithmetic helpers used by the sequencer
//   (target clamping and bounded slewing) so other channels can reuse them.
package servo_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } servo_state_e;

    // Duty code width; codes 0..99 map onto a 1.0..~2.0 ms pulse
    localparam int DUTY_W = 7;

    // Limits shared with the serializer
    localparam int MAX_DUTY_DEFAULT  = 99;
    localparam int HOME_DUTY_DEFAULT = 50;

    // 20 ms at 100 MHz; the serializer window uses the same value
    localparam int PWM_FRAME_CYCLES  = 2000000;

    // Clamp a requested duty code to the upper limit
    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] code,
        input logic [DUTY_W-1:0] max_code
    );
        if (code > max_code) begin
            clamp_duty = max_code;
        end else begin
            clamp_duty = code;
        end
    endfunction

    // Move duty toward target by at most step codes, never past the target.
    // The difference is taken one bit wider than a duty code so it is signed.
    function automatic logic [DUTY_W-1:0] slew_duty(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] target,
        input logic [DUTY_W-1:0] step
    );
        logic signed [DUTY_W:0] diff;
        logic        [DUTY_W:0] mag;
        logic        [DUTY_W:0] lim;
        diff = $signed({1'b0, target}) - $signed({1'b0, duty});
        if (diff[DUTY_W]) begin
            mag = $unsigned(-diff);
        end else begin
            mag = $unsigned(diff);
        end
        if (mag < {1'b0, step}) begin
            lim = mag;
        end else begin
            lim = {1'b0, step};
        end
        if (diff[DUTY_W]) begin
            slew_duty = DUTY_W'({1'b0, duty} - lim);
        end else begin
            slew_duty = DUTY_W'({1'b0, duty} + lim);
        end
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer
//   Free-running PWM frame counter. Counts 0..FRAME_CYCLES-1 and wraps.
//   frame_tick is high for exactly the cycle in which the count equals
//   FRAME_CYCLES-1. The tick is registered from the next-count value, so it
//   lines up with the count register without any combinational decode on
//   the output. The reset must be the same one that clears the serializer
//   so the two frame windows stay aligned.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   frame_tick  out  one-cycle pulse on the last cycle of each frame
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = PWM_FRAME_CYCLES
) (
    input  logic clk,
    input  logic reset,
    output logic frame_tick
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             tick_r;

    // Next count value with wrap at the end of the frame
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_r == LAST_C) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and registered tick (tick follows the count it belongs to)
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == LAST_C);
        end
    end

    assign frame_tick = tick_r;

endmodule

// File: rtl/servo_motion_sequencer.sv
// servo_motion_sequencer
//   Sequences position commands for one servo channel. Commands (target duty
//   code plus dwell frames) arrive over valid/ready into a one-entry pending
//   slot. At each frame boundary the sequencer either loads the pending
//   command, slews duty_cycle toward the target by at most STEP codes, or
//   counts down the dwell. duty_cycle only changes on frame_tick edges so the
//   serializer never sees a mid-pulse update. abort drops the pending command
//   and returns to IDLE immediately, leaving the servo where it is.
//
// Ports
//   clk         in   system clock, 100 MHz
//   reset       in   synchronous, active-high
//   cmd_valid   in   command offered
//   cmd_ready   out  pending slot free (low during reset and abort)
//   cmd_target  in   target duty code (clamped to MAX_DUTY on accept)
//   cmd_hold    in   extra dwell frames at target (hold N -> N+1 frames)
//   abort       in   synchronous abort, holds current position
//   duty_cycle  out  registered duty code for the serializer
//   frame_tick  out  one-cycle pulse on the last cycle of each frame
//   busy        out  state != IDLE or pending slot full
//   done        out  one-cycle pulse when a command's dwell completes
module servo_motion_sequencer
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = PWM_FRAME_CYCLES,
    parameter int STEP         = 4,
    parameter int HOME_DUTY    = HOME_DUTY_DEFAULT,
    parameter int MAX_DUTY     = MAX_DUTY_DEFAULT,
    parameter int HOLD_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              frame_tick,
    output logic              busy,
    output logic              done
);

    localparam logic [DUTY_W-1:0] STEP_C = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] HOME_C = DUTY_W'(HOME_DUTY);
    localparam logic [DUTY_W-1:0] MAX_C  = DUTY_W'(MAX_DUTY);

    servo_state_e      state_r;
    logic [DUTY_W-1:0] duty_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [DUTY_W-1:0] act_target_r;
    logic [HOLD_W-1:0] act_hold_r;
    logic              pend_valid_r;
    logic [DUTY_W-1:0] pend_target_r;
    logic [HOLD_W-1:0] pend_hold_r;
    logic              done_r;

    logic              frame_tick_s;
    logic              xfer_s;
    logic [DUTY_W-1:0] slew_s;
    logic [DUTY_W-1:0] target_clamp_s;

    servo_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick_s)
    );

    // The slot is free only when empty; abort and reset both refuse new work
    assign cmd_ready = !pend_valid_r && !abort && !reset;
    assign xfer_s    = cmd_valid && cmd_ready;

    // Clamped command target and next slewed duty value
    always_comb begin
        target_clamp_s = clamp_duty(cmd_target, MAX_C);
        slew_s         = slew_duty(duty_r, act_target_r, STEP_C);
    end

    // Sequencer FSM, pending slot and registered outputs.
    // Loading and accepting never collide: a load needs a full slot, an
    // accept needs an empty one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            duty_r        <= HOME_C;
            hold_cnt_r    <= {HOLD_W{1'b0}};
            act_target_r  <= HOME_C;
            act_hold_r    <= {HOLD_W{1'b0}};
            pend_valid_r  <= 1'b0;
            pend_target_r <= HOME_C;
            pend_hold_r   <= {HOLD_W{1'b0}};
            done_r        <= 1'b0;
        end else if (abort) begin
            // Stop where we are; no done pulse for an aborted command
            state_r      <= IDLE;
            pend_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (xfer_s) begin
                pend_valid_r  <= 1'b1;
                pend_target_r <= target_clamp_s;
                pend_hold_r   <= cmd_hold;
            end
            if (frame_tick_s) begin
                case (state_r)
                    IDLE: begin
                        // Load only; the first step happens on the next tick
                        if (pend_valid_r) begin
                            act_target_r <= pend_target_r;
                            act_hold_r   <= pend_hold_r;
                            pend_valid_r <= 1'b0;
                            state_r      <= RAMP;
                        end
                    end
                    RAMP: begin
                        if (duty_r == act_target_r) begin
                            state_r    <= HOLD;
                            hold_cnt_r <= act_hold_r;
                        end else begin
                            duty_r <= slew_s;
                            if (slew_s == act_target_r) begin
                                state_r    <= HOLD;
                                hold_cnt_r <= act_hold_r;
                            end
                        end
                    end
                    HOLD: begin
                        if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                            done_r <= 1'b1;
                            // Chain straight into a queued command
                            if (pend_valid_r) begin
                                act_target_r <= pend_target_r;
                                act_hold_r   <= pend_hold_r;
                                pend_valid_r <= 1'b0;
                                state_r      <= RAMP;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign duty_cycle = duty_r;
    assign frame_tick = frame_tick_s;
    assign done       = done_r;
    assign busy       = (state_r != IDLE) || pend_valid_r;

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Bench for servo_motion_sequencer with a 10-cycle frame and STEP of 4.
// Expected per-frame outputs (duty, done, busy) are queued when a command is
// issued and compared after each frame boundary.
module tb_servo_motion_sequencer;

    localparam int FRAME = 10;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_target;
    logic [7:0] cmd_hold;
    logic       abort;
    logic [6:0] duty_cycle;
    logic       frame_tick;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [6:0] duty;
        logic       done;
        logic       busy;
    } frame_exp_t;

    frame_exp_t exp_q[$];

    servo_motion_sequencer #(
        .FRAME_CYCLES (FRAME),
        .STEP         (4),
        .HOME_DUTY    (50),
        .MAX_DUTY     (99),
        .HOLD_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_hold   (cmd_hold),
        .abort      (abort),
        .duty_cycle (duty_cycle),
        .frame_tick (frame_tick),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the first cycle of the next frame (bounded)
    task automatic wait_frame();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
            step();
            n++;
        end
        vectors++;
        if (frame_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_wait: no frame_tick within %0d cycles", 3 * FRAME);
        end
        step();
    endtask

    task automatic push_exp(input logic [6:0] d, input logic dn, input logic b);
        frame_exp_t e;
        e.duty = d;
        e.done = dn;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic pop_frame(output frame_exp_t e);
        wait_frame();
        e = exp_q.pop_front();
    endtask

    task automatic send_cmd(input logic [6:0] t, input logic [7:0] h);
        int n = 0;
        cmd_target = t;
        cmd_hold   = h;
        cmd_valid  = 1'b1;
        while (cmd_ready !== 1'b1 && n < 4 * FRAME) begin
            step();
            n++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=%b, expected 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        int m = 0;
        reset = 1'b1;
        repeat (3) step();
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: cmd_ready=%b, expected 0", cmd_ready);
        end
        vectors++;
        if (duty_cycle !== 7'd50 || busy !== 1'b0 || done !== 1'b0 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: duty=%0d busy=%b done=%b tick=%b, expected 50 0 0 0",
                     duty_cycle, busy, done, frame_tick);
        end
        reset = 1'b0;
        while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
            step();
            n++;
        end
        vectors++;
        if (n !== FRAME - 1) begin
            miscompares++;
            $display("FAIL first_tick: tick after %0d cycles, expected %0d", n, FRAME - 1);
        end
        do begin
            step();
            m++;
        end while (frame_tick !== 1'b1 && m < 3 * FRAME);
        vectors++;
        if (m !== FRAME) begin
            miscompares++;
            $display("FAIL tick_period: period %0d, expected %0d", m, FRAME);
        end
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || duty_cycle !== 7'd50) begin
            miscompares++;
            $display("FAIL idle_outputs: ready=%b busy=%b duty=%0d, expected 1 0 50",
                     cmd_ready, busy, duty_cycle);
        end
        wait_frame();
    endtask

    task automatic test_same_target();
        frame_exp_t e;
        int f = 0;
        send_cmd(7'd50, 8'd0);
        push_exp(7'd50, 1'b0, 1'b1);
        push_exp(7'd50, 1'b0, 1'b1);
        push_exp(7'd50, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            pop_frame(e);
            f++;
            vectors++;
            if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy) begin
                miscompares++;
                $display("FAIL same_target_f%0d: duty=%0d done=%b busy=%b, expected %0d %b %b",
                         f, duty_cycle, done, busy, e.duty, e.done, e.busy);
            end
        end
    endtask

    task automatic test_ramp_hold();
        frame_exp_t e;
        int f = 0;
        send_cmd(7'd60, 8'd2);
        push_exp(7'd50, 1'b0, 1'b1);
        push_exp(7'd54, 1'b0, 1'b1);
        push_exp(7'd58, 1'b0, 1'b1);
        push_exp(7'd60, 1'b0, 1'b1);
        push_exp(7'd60, 1'b0, 1'b1);
        push_exp(7'd60, 1'b0, 1'b1);
        push_exp(7'd60, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            pop_frame(e);
            f++;
            vectors++;
            if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy) begin
                miscompares++;
                $display("FAIL ramp_f%0d: duty=%0d done=%b busy=%b, expected %0d %b %b",
                         f, duty_cycle, done, busy, e.duty, e.done, e.busy);
            end
        end
        step();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_width: done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_clamp();
        frame_exp_t e;
        int f = 0;
        send_cmd(7'd120, 8'd0);
        push_exp(7'd60, 1'b0, 1'b1);
        for (int d = 64; d <= 96; d += 4) push_exp(7'(d), 1'b0, 1'b1);
        push_exp(7'd99, 1'b0, 1'b1);
        push_exp(7'd99, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            pop_frame(e);
            f++;
            vectors++;
            if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy) begin
                miscompares++;
                $display("FAIL clamp_f%0d: duty=%0d done=%b busy=%b, expected %0d %b %b",
                         f, duty_cycle, done, busy, e.duty, e.done, e.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_exp_t e;
        int f = 1;
        send_cmd(7'd60, 8'd0);
        vectors++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_slot_full: ready=%b busy=%b, expected 0 1", cmd_ready, busy);
        end
        cmd_target = 7'd30;
        cmd_hold   = 8'd0;
        cmd_valid  = 1'b1;
        push_exp(7'd99, 1'b0, 1'b1);
        for (int d = 95; d >= 63; d -= 4) push_exp(7'(d), 1'b0, 1'b1);
        push_exp(7'd60, 1'b0, 1'b1);
        push_exp(7'd60, 1'b1, 1'b1);
        for (int d = 56; d >= 32; d -= 4) push_exp(7'(d), 1'b0, 1'b1);
        push_exp(7'd30, 1'b0, 1'b1);
        push_exp(7'd30, 1'b1, 1'b0);
        pop_frame(e);
        vectors++;
        if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy) begin
            miscompares++;
            $display("FAIL b2b_f1: duty=%0d done=%b busy=%b, expected %0d %b %b",
                     duty_cycle, done, busy, e.duty, e.done, e.busy);
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_slot_freed: cmd_ready=%b, expected 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_taken: cmd_ready=%b, expected 0", cmd_ready);
        end
        while (exp_q.size() > 0) begin
            pop_frame(e);
            f++;
            vectors++;
            if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy) begin
                miscompares++;
                $display("FAIL b2b_f%0d: duty=%0d done=%b busy=%b, expected %0d %b %b",
                         f, duty_cycle, done, busy, e.duty, e.done, e.busy);
            end
        end
    endtask

    task automatic test_abort();
        frame_exp_t e;
        int f = 0;
        int n = 0;
        send_cmd(7'd70, 8'd0);
        for (int d = 30; d <= 54; d += 4) push_exp(7'(d), 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            pop_frame(e);
            f++;
            vectors++;
            if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy) begin
                miscompares++;
                $display("FAIL abort_ramp_f%0d: duty=%0d done=%b busy=%b, expected %0d %b %b",
                         f, duty_cycle, done, busy, e.duty, e.done, e.busy);
            end
        end
        abort      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_target = 7'd10;
        cmd_hold   = 8'd0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ready: cmd_ready=%b, expected 0", cmd_ready);
        end
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        vectors++;
        if (duty_cycle !== 7'd54 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: duty=%0d busy=%b done=%b, expected 54 0 0",
                     duty_cycle, busy, done);
        end
        while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
            step();
            n++;
        end
        vectors++;
        if (n !== FRAME - 2) begin
            miscompares++;
            $display("FAIL abort_timer: tick after %0d cycles, expected %0d", n, FRAME - 2);
        end
        repeat (3) push_exp(7'd54, 1'b0, 1'b0);
        f = 0;
        while (exp_q.size() > 0) begin
            pop_frame(e);
            f++;
            vectors++;
            if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy) begin
                miscompares++;
                $display("FAIL abort_idle_f%0d: duty=%0d done=%b busy=%b, expected %0d %b %b",
                         f, duty_cycle, done, busy, e.duty, e.done, e.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        frame_exp_t e;
        int f = 0;
        send_cmd(7'd70, 8'd3);
        push_exp(7'd54, 1'b0, 1'b1);
        push_exp(7'd58, 1'b0, 1'b1);
        push_exp(7'd62, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            pop_frame(e);
            f++;
            vectors++;
            if (duty_cycle !== e.duty || done !== e.done || busy !== e.busy) begin
                miscompares++;
                $display("FAIL midreset_f%0d: duty=%0d done=%b busy=%b, expected %0d %b %b",
                         f, duty_cycle, done, busy, e.duty, e.done, e.busy);
            end
        end
        reset = 1'b1;
        step();
        vectors++;
        if (duty_cycle !== 7'd50 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: duty=%0d busy=%b done=%b ready=%b, expected 50 0 0 0",
                     duty_cycle, busy, done, cmd_ready);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (cmd_ready !== 1'b1 || duty_cycle !== 7'd50) begin
            miscompares++;
            $display("FAIL midreset_release: ready=%b duty=%0d, expected 1 50", cmd_ready, duty_cycle);
        end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 7'd0;
        cmd_hold   = 8'd0;
        abort      = 1'b0;
        test_reset();
        test_same_target();
        test_ramp_hold();
        test_clamp();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
